muldiv_sequencer: RTL and testbench

//  Sequences the multicycle Mult and Div units on behalf of the main control FSM.

---
 rtl/muldiv_sequencer_if.sv | 31 +++
 rtl/muldiv_sequencer.sv | 126 ++++++++++++
 tb/tb_muldiv_sequencer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// Handshake bundle between the main control FSM, the Mult/Div units and the sequencer.
// The sequencer takes the slave side; the controller/units (or a bench) take the master side.
interface muldiv_sequencer_if;
    logic start;
    logic op;
    logic abort;
    logic mult_done;
    logic div_done;
    logic div_zero;
    logic mult_start;
    logic div_start;
    logic hilo_sel;
    logic write_hi;
    logic write_lo;
    logic busy;
    logic done;
    logic div0_exc;
    logic timeout_err;

    modport slave (
        input  start, op, abort, mult_done, div_done, div_zero,
        output mult_start, div_start, hilo_sel, write_hi, write_lo,
               busy, done, div0_exc, timeout_err
    );

    modport master (
        output start, op, abort, mult_done, div_done, div_zero,
        input  mult_start, div_start, hilo_sel, write_hi, write_lo,
               busy, done, div0_exc, timeout_err
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Launches one Mult or Div operation at a time, waits for its done and writes HI/LO.
// Every output is a flop computed from the next state, so outputs line up with the state.
module muldiv_sequencer #(
    parameter int CNT_W   = 6,
    parameter int TIMEOUT = 40
) (
    input  logic             clock,
    input  logic             reset,
    muldiv_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_WB,
        S_DONE,
        S_EXC,
        S_TOUT
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic             op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic mult_start_q, mult_start_d;
    logic div_start_q,  div_start_d;
    logic hilo_sel_q,   hilo_sel_d;
    logic write_q,      write_d;
    logic busy_q,       busy_d;
    logic done_q,       done_d;
    logic div0_exc_q,   div0_exc_d;
    logic tout_q,       tout_d;

    logic unit_done;

    // Only the unit that was launched can complete the operation.
    assign unit_done = op_q ? bus.div_done : bus.mult_done;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                cnt_d   = '0;
                state_d = bus.abort ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.abort)
                    state_d = S_IDLE;
                else if (op_q && bus.div_zero)
                    state_d = S_EXC;
                else if (unit_done)
                    state_d = S_WB;
                else if (cnt_q == CNT_LAST)
                    state_d = S_TOUT;
            end
            S_WB:    state_d = bus.abort ? S_IDLE : S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_EXC:   state_d = S_IDLE;
            S_TOUT:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mult_start_d = (state_d == S_LAUNCH) && !op_d;
        div_start_d  = (state_d == S_LAUNCH) &&  op_d;
        write_d      = (state_d == S_WB);
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
        div0_exc_d   = (state_d == S_EXC);
        tout_d       = (state_d == S_TOUT);
        // The mux select is sticky; it only moves when a write is actually issued.
        hilo_sel_d   = (state_d == S_WB) ? ~op_q : hilo_sel_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            op_q         <= 1'b0;
            cnt_q        <= '0;
            mult_start_q <= 1'b0;
            div_start_q  <= 1'b0;
            hilo_sel_q   <= 1'b0;
            write_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            div0_exc_q   <= 1'b0;
            tout_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            cnt_q        <= cnt_d;
            mult_start_q <= mult_start_d;
            div_start_q  <= div_start_d;
            hilo_sel_q   <= hilo_sel_d;
            write_q      <= write_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            div0_exc_q   <= div0_exc_d;
            tout_q       <= tout_d;
        end
    end

    assign bus.mult_start  = mult_start_q;
    assign bus.div_start   = div_start_q;
    assign bus.hilo_sel    = hilo_sel_q;
    assign bus.write_hi    = write_q;
    assign bus.write_lo    = write_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div0_exc    = div0_exc_q;
    assign bus.timeout_err = tout_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized bench for muldiv_sequencer: each operation is planned as a scenario
// (op, event kind, event cycle, aborts) and the expected per-cycle outputs follow from it.
module tb_muldiv_sequencer;

    localparam int TO = 40;

    localparam int K_DONE  = 0;
    localparam int K_ZERO  = 1;
    localparam int K_ABORT = 2;
    localparam int K_NONE  = 3;

    logic clock;
    logic reset;

    muldiv_sequencer_if bus();

    muldiv_sequencer #(.CNT_W(6), .TIMEOUT(TO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int   n_chk  = 0;
    int   n_pass = 0;
    logic exp_hilo = 1'b0;

    task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s @%0t: got %b expected %b (ms ds sel whi wlo busy done exc tout)",
                     tag, $time, got, exp);
    endtask

    function automatic logic [8:0] obs();
        return {bus.mult_start, bus.div_start, bus.hilo_sel, bus.write_hi, bus.write_lo,
                bus.busy, bus.done, bus.div0_exc, bus.timeout_err};
    endfunction

    // Expected output vector; the mux select comes from the bench's own history.
    function automatic logic [8:0] ev(input logic ms, input logic ds, input logic wr,
                                      input logic b, input logic d, input logic e,
                                      input logic t);
        return {ms, ds, exp_hilo, wr, wr, b, d, e, t};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_in();
        bus.start     = 1'b0;
        bus.op        = 1'b0;
        bus.abort     = 1'b0;
        bus.mult_done = 1'b0;
        bus.div_done  = 1'b0;
        bus.div_zero  = 1'b0;
    endtask

    // Outside WAIT every unit input must be ignored, so drive them randomly.
    task automatic noise_out();
        bus.start     = 1'b0;
        bus.mult_done = 1'($urandom);
        bus.div_done  = 1'($urandom);
        bus.div_zero  = 1'($urandom);
    endtask

    // Inside WAIT only inputs that must not matter: the other unit's done,
    // div_zero on a mult, and a repeated start.
    task automatic noise_wait(input logic op);
        bus.start     = 1'($urandom);
        bus.op        = 1'($urandom);
        bus.mult_done = op ? 1'($urandom) : 1'b0;
        bus.div_done  = op ? 1'b0 : 1'($urandom);
        bus.div_zero  = op ? 1'b0 : 1'($urandom);
    endtask

    task automatic run_op(input logic op, input int kind, input int w,
                          input bit ab_launch, input bit ab_wb, input bit start_abort,
                          input bit force_start);
        bus.start = 1'b1;
        bus.op    = op;
        bus.abort = start_abort;
        step();
        chk("launch", obs(), ev(~op, op, 0, 1, 0, 0, 0));
        noise_out();
        bus.op    = 1'($urandom);
        bus.abort = ab_launch;
        if (ab_launch) begin
            step();
            chk("abort_launch", obs(), ev(0, 0, 0, 0, 0, 0, 0));
            clear_in();
            return;
        end
        for (int j = 0; j < TO; j++) begin
            step();
            chk("wait", obs(), ev(0, 0, 0, 1, 0, 0, 0));
            bus.abort = 1'b0;
            if (kind != K_NONE && j == w) begin
                bus.start = force_start ? 1'b1 : 1'($urandom);
                case (kind)
                    K_DONE: begin
                        bus.mult_done = op ? 1'($urandom) : 1'b1;
                        bus.div_done  = op ? 1'b1 : 1'($urandom);
                        bus.div_zero  = op ? 1'b0 : 1'($urandom);
                    end
                    K_ZERO: begin
                        bus.div_zero  = 1'b1;
                        bus.div_done  = 1'($urandom);
                        bus.mult_done = 1'($urandom);
                    end
                    default: begin
                        bus.abort     = 1'b1;
                        bus.mult_done = 1'($urandom);
                        bus.div_done  = 1'($urandom);
                        bus.div_zero  = 1'($urandom);
                    end
                endcase
                break;
            end
            noise_wait(op);
            if (force_start) bus.start = 1'b1;
        end
        step();
        bus.abort = 1'b0;
        noise_out();
        case (kind)
            K_DONE: begin
                exp_hilo = ~op;
                chk("wb", obs(), ev(0, 0, 1, 1, 0, 0, 0));
                bus.abort = ab_wb;
                step();
                bus.abort = 1'b0;
                if (ab_wb) begin
                    chk("abort_wb", obs(), ev(0, 0, 0, 0, 0, 0, 0));
                end else begin
                    chk("done", obs(), ev(0, 0, 0, 1, 1, 0, 0));
                    step();
                    chk("done_idle", obs(), ev(0, 0, 0, 0, 0, 0, 0));
                end
            end
            K_ZERO: begin
                chk("exc", obs(), ev(0, 0, 0, 1, 0, 1, 0));
                step();
                chk("exc_idle", obs(), ev(0, 0, 0, 0, 0, 0, 0));
            end
            K_ABORT: chk("abort_wait", obs(), ev(0, 0, 0, 0, 0, 0, 0));
            default: begin
                chk("tout", obs(), ev(0, 0, 0, 1, 0, 0, 1));
                step();
                chk("tout_idle", obs(), ev(0, 0, 0, 0, 0, 0, 0));
            end
        endcase
        clear_in();
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            bus.abort     = 1'($urandom);
            bus.mult_done = 1'($urandom);
            bus.div_done  = 1'($urandom);
            bus.div_zero  = 1'($urandom);
            step();
            chk("idle", obs(), ev(0, 0, 0, 0, 0, 0, 0));
        end
        clear_in();
    endtask

    initial begin
        clear_in();
        reset = 1'b1;
        #2;
        chk("reset", obs(), 9'b0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        chk("reset_release", obs(), ev(0, 0, 0, 0, 0, 0, 0));

        // Directed: mult done 33 cycles after mult_start, div done after 32.
        run_op(1'b0, K_DONE, 32, 0, 0, 0, 0);
        run_op(1'b1, K_DONE, 31, 0, 0, 0, 0);
        // div_zero and div_done together: exception only.
        run_op(1'b1, K_ZERO, 5, 0, 0, 0, 0);
        // No done at all: watchdog.
        run_op(1'b0, K_NONE, 0, 0, 0, 0, 0);
        // Repeated start while busy, then abort together with mult_done.
        run_op(1'b0, K_ABORT, 10, 0, 0, 0, 1);
        // Edge event cycles: first and last WAIT cycle.
        run_op(1'b1, K_DONE, 0, 0, 0, 1, 0);
        run_op(1'b0, K_DONE, TO - 1, 0, 0, 0, 0);
        run_op(1'b1, K_ZERO, TO - 1, 0, 0, 0, 0);
        run_op(1'b0, K_DONE, 3, 1, 0, 0, 0);
        run_op(1'b1, K_DONE, 3, 0, 1, 0, 0);

        // Asynchronous reset in the middle of a mult WAIT with hilo_sel = 1.
        run_op(1'b0, K_DONE, 2, 0, 0, 0, 0);
        bus.start = 1'b1;
        bus.op    = 1'b0;
        step();
        chk("rst_launch", obs(), ev(1, 0, 0, 1, 0, 0, 0));
        clear_in();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rst_wait", obs(), ev(0, 0, 0, 1, 0, 0, 0));
        end
        #3;
        reset = 1'b1;
        #1;
        exp_hilo = 1'b0;
        chk("async_reset", obs(), 9'b0);
        step();
        chk("reset_hold", obs(), 9'b0);
        reset = 1'b0;
        step();
        chk("post_reset_idle", obs(), ev(0, 0, 0, 0, 0, 0, 0));
        run_op(1'b1, K_DONE, 7, 0, 0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            logic op;
            int   kind;
            op   = 1'($urandom);
            kind = int'($urandom_range(0, 3));
            if (kind == K_ZERO && !op) kind = K_DONE;
            run_op(op, kind, int'($urandom_range(0, TO - 1)), ($urandom_range(0, 9) == 0),
                   ($urandom_range(0, 7) == 0), 1'($urandom), 1'b0);
            idle_gap(int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
